soc_nios_ii_div_cell: RTL and testbench

Iterative radix-2 restoring divider. It is the inverse-operation companion to the CPU's pipelined multiply cell and backs the Nios II div/divu path. It takes two WIDTH-bit operands on a start pulse, runs one quotient bit per clock, and returns either the quotient or the remainder with a single-cycle done pulse. It sits beside the multiply cell in the M stage; the CPU stalls on busy.

---
 rtl/soc_nios_ii_div_cell_pkg.sv | 24 ++
 rtl/soc_nios_ii_div_cell_step.sv | 38 +++
 rtl/soc_nios_ii_div_cell.sv | 191 +++++++++++++++++++
 tb/tb_soc_nios_ii_div_cell.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/soc_nios_ii_div_cell_pkg.sv
// Shared definitions for the iterative radix-2 divider cell.
// Contents:
//   state_t       - controller states (IDLE -> CALC -> FIX -> IDLE)
//   DIV_WIDTH     - default operand width
//   DIV_CNT_W     - default iteration counter width
//   DIV_MSB       - sign-bit index for the default width
//   DIV_ALL_ONES  - divide-by-zero quotient for the default width
//   DIV_MOST_NEG  - most-negative two's-complement value for the default width
package soc_nios_ii_div_cell_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = 6;
  localparam int DIV_MSB   = DIV_WIDTH - 1;

  localparam logic [DIV_WIDTH-1:0] DIV_ALL_ONES = {DIV_WIDTH{1'b1}};
  localparam logic [DIV_WIDTH-1:0] DIV_MOST_NEG = {1'b1, {DIV_MSB{1'b0}}};

endpackage

// File: rtl/soc_nios_ii_div_cell_step.sv
// One restoring-division step: shifts the {rem, dvd} pair left by one bit,
// trial-subtracts the divisor from the partial remainder and shifts the
// resulting quotient bit into the LSB of dvd.
// Ports:
//   rem_in   [WIDTH:0]   partial remainder before the step
//   dvd_in   [WIDTH-1:0] dividend/quotient shift register before the step
//   divisor  [WIDTH-1:0] divisor magnitude
//   rem_out  [WIDTH:0]   partial remainder after the step
//   dvd_out  [WIDTH-1:0] dividend/quotient shift register after the step
module soc_nios_ii_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic [WIDTH-1:0] dvd_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic [WIDTH-1:0] dvd_out
);

  logic [WIDTH:0] shifted_s;
  logic [WIDTH:0] diff_s;

  // Shift, trial-subtract, and either keep the difference or restore.
  always_comb begin
    shifted_s = {rem_in[WIDTH-1:0], dvd_in[WIDTH-1]};
    diff_s    = shifted_s - {1'b0, divisor};
    // The remainder stays below the divisor, so the difference is always
    // within +-(2**WIDTH - 1) and bit WIDTH is a reliable sign bit.
    if (diff_s[WIDTH] == 1'b0) begin
      rem_out = diff_s;
      dvd_out = {dvd_in[WIDTH-2:0], 1'b1};
    end else begin
      rem_out = shifted_s;
      dvd_out = {dvd_in[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/soc_nios_ii_div_cell.sv
// Iterative radix-2 restoring divider backing div/divu. One quotient bit per
// clock; returns either quotient or remainder with a one-cycle done pulse.
// Ports:
//   clk, reset_n     clock (rising edge), asynchronous active-low reset
//   start            request, taken only while busy=0
//   div_src1/2       dividend / divisor, sampled with start
//   is_signed        two's-complement division when 1
//   want_rem         return remainder when 1, quotient when 0
//   busy             high from the cycle after acceptance until done
//   done             one-cycle pulse, div_cell_result valid
//   div_cell_result  result, held until the next operation completes
module soc_nios_ii_div_cell
  import soc_nios_ii_div_cell_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] div_src1,
  input  logic [WIDTH-1:0] div_src2,
  input  logic             is_signed,
  input  logic             want_rem,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] div_cell_result
);

  localparam int MSB = WIDTH - 1;
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  // Two's-complement negation at the operand width.
  function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] x);
    return -x;
  endfunction

  state_t            state_r, state_s;
  logic [WIDTH:0]    rem_r, rem_s;
  logic [WIDTH-1:0]  dvd_r, dvd_s;
  logic [WIDTH-1:0]  divisor_r, divisor_s;
  logic [WIDTH-1:0]  src1_r, src1_s;
  logic [CNT_W-1:0]  count_r, count_s;
  logic              sign_q_r, sign_q_s;
  logic              sign_r_r, sign_r_s;
  logic              want_rem_r, want_rem_s;
  logic              dbz_r, dbz_s;
  logic              busy_r, busy_s;
  logic              done_r, done_s;
  logic [WIDTH-1:0]  result_r, result_s;

  logic [WIDTH:0]    step_rem_s;
  logic [WIDTH-1:0]  step_dvd_s;
  logic [WIDTH-1:0]  quot_fix_s;
  logic [WIDTH-1:0]  rem_fix_s;

  soc_nios_ii_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_r),
    .dvd_in  (dvd_r),
    .divisor (divisor_r),
    .rem_out (step_rem_s),
    .dvd_out (step_dvd_s)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      rem_r      <= '0;
      dvd_r      <= '0;
      divisor_r  <= '0;
      src1_r     <= '0;
      count_r    <= '0;
      sign_q_r   <= 1'b0;
      sign_r_r   <= 1'b0;
      want_rem_r <= 1'b0;
      dbz_r      <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      result_r   <= '0;
    end else begin
      state_r    <= state_s;
      rem_r      <= rem_s;
      dvd_r      <= dvd_s;
      divisor_r  <= divisor_s;
      src1_r     <= src1_s;
      count_r    <= count_s;
      sign_q_r   <= sign_q_s;
      sign_r_r   <= sign_r_s;
      want_rem_r <= want_rem_s;
      dbz_r      <= dbz_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
      result_r   <= result_s;
    end
  end

  // Sign fix-up of the magnitudes; divide-by-zero overrides the datapath.
  always_comb begin
    quot_fix_s = dvd_r;
    rem_fix_s  = rem_r[MSB:0];
    if (dbz_r) begin
      quot_fix_s = ALL_ONES;
      rem_fix_s  = src1_r;
    end else begin
      if (sign_q_r) begin
        quot_fix_s = neg(dvd_r);
      end else begin
        quot_fix_s = dvd_r;
      end
      if (sign_r_r) begin
        rem_fix_s = neg(rem_r[MSB:0]);
      end else begin
        rem_fix_s = rem_r[MSB:0];
      end
    end
  end

  // Next-state and next-register logic for the controller.
  always_comb begin
    state_s    = state_r;
    rem_s      = rem_r;
    dvd_s      = dvd_r;
    divisor_s  = divisor_r;
    src1_s     = src1_r;
    count_s    = count_r;
    sign_q_s   = sign_q_r;
    sign_r_s   = sign_r_r;
    want_rem_s = want_rem_r;
    dbz_s      = dbz_r;
    busy_s     = busy_r;
    done_s     = 1'b0;
    result_s   = result_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          if (is_signed && div_src1[MSB]) begin
            dvd_s = neg(div_src1);
          end else begin
            dvd_s = div_src1;
          end
          if (is_signed && div_src2[MSB]) begin
            divisor_s = neg(div_src2);
          end else begin
            divisor_s = div_src2;
          end
          sign_q_s   = is_signed & (div_src1[MSB] ^ div_src2[MSB]);
          sign_r_s   = is_signed & div_src1[MSB];
          want_rem_s = want_rem;
          dbz_s      = (div_src2 == {WIDTH{1'b0}});
          src1_s     = div_src1;
          rem_s      = '0;
          count_s    = CNT_W'(WIDTH);
          busy_s     = 1'b1;
          state_s    = ST_CALC;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CALC: begin
        rem_s   = step_rem_s;
        dvd_s   = step_dvd_s;
        count_s = count_r - CNT_W'(1);
        if (count_r == CNT_W'(1)) begin
          state_s = ST_FIX;
        end else begin
          state_s = ST_CALC;
        end
      end
      ST_FIX: begin
        if (want_rem_r) begin
          result_s = rem_fix_s;
        end else begin
          result_s = quot_fix_s;
        end
        done_s  = 1'b1;
        busy_s  = 1'b0;
        state_s = ST_IDLE;
      end
      default: begin
        busy_s  = 1'b0;
        state_s = ST_IDLE;
      end
    endcase
  end

  assign busy            = busy_r;
  assign done            = done_r;
  assign div_cell_result = result_r;

endmodule

// File: tb/tb_soc_nios_ii_div_cell.sv
module tb_soc_nios_ii_div_cell;

  localparam int LAT = 33;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [31:0] div_src1;
  logic [31:0] div_src2;
  logic        is_signed;
  logic        want_rem;
  logic        busy;
  logic        done;
  logic [31:0] div_cell_result;

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [31:0] exp_q[$];

  soc_nios_ii_div_cell #(.WIDTH(32), .CNT_W(6)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .start           (start),
    .div_src1        (div_src1),
    .div_src2        (div_src2),
    .is_signed       (is_signed),
    .want_rem        (want_rem),
    .busy            (busy),
    .done            (done),
    .div_cell_result (div_cell_result)
  );

  always #5 clk = ~clk;

  // Reference: 64-bit language division (truncating, remainder follows dividend).
  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input bit s, input bit wr);
    longint sa, sb, q, r;
    if (b == 32'd0) return wr ? a : 32'hFFFF_FFFF;
    if (s) begin
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
    end else begin
      sa = {32'd0, a};
      sb = {32'd0, b};
    end
    q = sa / sb;
    r = sa % sb;
    return wr ? r[31:0] : q[31:0];
  endfunction

  // Present one request for one edge, then scramble the inputs.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit s, input bit wr);
    div_src1  = a;
    div_src2  = b;
    is_signed = s;
    want_rem  = wr;
    start     = 1'b1;
    exp_q.push_back(model(a, b, s, wr));
    @(posedge clk);
    #1;
    start     = 1'b0;
    div_src1  = $urandom;
    div_src2  = $urandom;
    is_signed = 1'($urandom_range(0, 1));
    want_rem  = 1'($urandom_range(0, 1));
  endtask

  // Count edges until done (bounded); optionally pulse start at one cycle.
  task automatic wait_done(input int poke_at, output int cycles, output bit held);
    logic [31:0] prev;
    prev   = div_cell_result;
    cycles = 0;
    held   = 1'b1;
    while (done !== 1'b1 && cycles < 100) begin
      start = (cycles == poke_at);
      @(posedge clk);
      #1;
      cycles++;
      if (done !== 1'b1 && div_cell_result !== prev) held = 1'b0;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    start = 1'b0; div_src1 = '0; div_src2 = '0; is_signed = 1'b0; want_rem = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b want 0", busy); else pass_cnt++;
    total_cnt++; if (done !== 1'b0) $display("FAIL reset_done: got %0b want 0", done); else pass_cnt++;
    total_cnt++; if (div_cell_result !== 32'd0) $display("FAIL reset_result: got %h want 0", div_cell_result); else pass_cnt++;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Runs a table of divides, checking latency, value, hold and pulse width.
  task automatic run_table(input string name, input logic [31:0] ta[8], input logic [31:0] tb[8],
                           input bit s[8], input bit wr[8]);
    int cyc; bit held; logic [31:0] e;
    for (int i = 0; i < 8; i++) begin
      issue(ta[i], tb[i], s[i], wr[i]);
      total_cnt++; if (busy !== 1'b1) $display("FAIL %s_busy[%0d]: got %0b want 1", name, i, busy); else pass_cnt++;
      wait_done(-1, cyc, held);
      e = exp_q.pop_front();
      total_cnt++; if (cyc !== LAT) $display("FAIL %s_latency[%0d]: got %0d want %0d", name, i, cyc, LAT); else pass_cnt++;
      total_cnt++; if (div_cell_result !== e) $display("FAIL %s_result[%0d]: %h/%h got %h want %h", name, i, ta[i], tb[i], div_cell_result, e); else pass_cnt++;
      total_cnt++; if (held !== 1'b1) $display("FAIL %s_hold[%0d]: result moved before done", name, i); else pass_cnt++;
      @(posedge clk);
      #1;
      total_cnt++; if (done !== 1'b0 || div_cell_result !== e) $display("FAIL %s_after[%0d]: done %0b result %h want 0 %h", name, i, done, div_cell_result, e); else pass_cnt++;
    end
  endtask

  task automatic test_unsigned();
    logic [31:0] ta[8] = '{32'd100, 32'd100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'hDEAD_BEEF, $urandom, $urandom};
    logic [31:0] tb[8] = '{32'd7, 32'd7, 32'd1, 32'd1, 32'd9, 32'h0001_2345, $urandom, 32'd3};
    bit s[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    bit wr[8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    run_table("unsigned", ta, tb, s, wr);
  endtask

  task automatic test_signed();
    logic [31:0] ta[8] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'd7, 32'h8000_0000, 32'h8000_0000, $urandom, 32'hFFFF_FF00};
    logic [31:0] tb[8] = '{32'd2, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, $urandom, 32'hFFFF_FFF3};
    bit s[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    bit wr[8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    run_table("signed", ta, tb, s, wr);
  endtask

  task automatic test_div_zero();
    logic [31:0] ta[8] = '{32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 32'h8765_4321, 32'h8765_4321, 32'd0, 32'd0};
    logic [31:0] tb[8] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    bit s[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    bit wr[8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    run_table("divzero", ta, tb, s, wr);
  endtask

  task automatic test_back_to_back();
    int cyc; bit held; logic [31:0] e;
    issue(32'd100, 32'd7, 1'b0, 1'b0);
    wait_done(10, cyc, held);
    e = exp_q.pop_front();
    total_cnt++; if (cyc !== LAT) $display("FAIL ignored_start_latency: got %0d want %0d", cyc, LAT); else pass_cnt++;
    total_cnt++; if (div_cell_result !== e) $display("FAIL ignored_start_result: got %h want %h", div_cell_result, e); else pass_cnt++;
    total_cnt++; if (held !== 1'b1) $display("FAIL ignored_start_hold: result moved before done"); else pass_cnt++;
    // Issue the next request in the same cycle done is high.
    issue(32'd200, 32'd3, 1'b0, 1'b1);
    total_cnt++; if (busy !== 1'b1) $display("FAIL b2b_accept: busy %0b want 1", busy); else pass_cnt++;
    wait_done(-1, cyc, held);
    total_cnt++; if (cyc !== LAT) $display("FAIL b2b_latency: got %0d want %0d", cyc, LAT); else pass_cnt++;
    total_cnt++; if (held !== 1'b1) $display("FAIL b2b_hold: first result did not hold"); else pass_cnt++;
    e = exp_q.pop_front();
    total_cnt++; if (div_cell_result !== e) $display("FAIL b2b_result: got %h want %h", div_cell_result, e); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int cyc; bit held; logic [31:0] e;
    issue(32'd1000, 32'd9, 1'b0, 1'b0);
    repeat (14) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    void'(exp_q.pop_back());
    total_cnt++; if (busy !== 1'b0) $display("FAIL midreset_busy: got %0b want 0", busy); else pass_cnt++;
    total_cnt++; if (done !== 1'b0) $display("FAIL midreset_done: got %0b want 0", done); else pass_cnt++;
    total_cnt++; if (div_cell_result !== 32'd0) $display("FAIL midreset_result: got %h want 0", div_cell_result); else pass_cnt++;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    issue(32'd100, 32'd7, 1'b0, 1'b0);
    wait_done(-1, cyc, held);
    e = exp_q.pop_front();
    total_cnt++; if (cyc !== LAT) $display("FAIL postreset_latency: got %0d want %0d", cyc, LAT); else pass_cnt++;
    total_cnt++; if (div_cell_result !== e) $display("FAIL postreset_result: got %h want %h", div_cell_result, e); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
